// File: rtl/smi_arb_pkg.sv
// Shared types and sizing helpers for the SMI frame arbiter.
package smi_arb_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StLocked
  } arb_state_e;

  // Per-frame beat counter width; wide enough for any legal MaxFrameBeats.
  localparam int unsigned BeatCntWidth = 16;

  function automatic int unsigned port_idx_width(input int unsigned num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/smi_rr_pick.sv
// Combinational round-robin picker: first requester after last_i, wrapping to 0.
module smi_rr_pick
  import smi_arb_pkg::*;
#(
  parameter int unsigned NumPorts = 4,
  parameter int unsigned IdxWidth = port_idx_width(NumPorts)
) (
  input  logic [NumPorts-1:0] req_i,
  input  logic [IdxWidth-1:0] last_i,
  output logic [IdxWidth-1:0] grant_o,
  output logic                any_o
);

  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumPorts - 1);

  logic [IdxWidth-1:0] idx;

  always_comb begin
    grant_o = last_i;
    any_o   = 1'b0;
    idx     = last_i;
    for (int unsigned k = 0; k < NumPorts; k++) begin
      idx = (idx == LastIdx) ? '0 : idx + IdxWidth'(1);
      if (!any_o && req_i[idx]) begin
        grant_o = idx;
        any_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/smi_frame_arbiter.sv
// Frame-atomic round-robin merge of NumPorts beat streams into one registered output.
module smi_frame_arbiter
  import smi_arb_pkg::*;
#(
  parameter int unsigned DataWidth     = 16,
  parameter int unsigned NumPorts      = 4,
  parameter int unsigned MaxFrameBeats = 64,
  localparam int unsigned IdxWidth     = port_idx_width(NumPorts)
) (
  input  logic                          clk,
  input  logic                          arstn,
  input  logic [NumPorts-1:0]           dataInValid,
  input  logic [NumPorts*DataWidth-1:0] dataIn,
  input  logic [NumPorts-1:0]           dataInEofc,
  output logic [NumPorts-1:0]           dataInStop,
  output logic                          dataOutValid,
  output logic [DataWidth-1:0]          dataOut,
  output logic                          dataOutEofc,
  input  logic                          dataOutStop,
  output logic [IdxWidth-1:0]           grantPort,
  output logic                          frameOverrun
);

  localparam logic [BeatCntWidth-1:0] MaxCnt  = BeatCntWidth'(MaxFrameBeats);
  localparam logic [IdxWidth-1:0]     LastIdx = IdxWidth'(NumPorts - 1);

  arb_state_e state_q, state_d;
  logic [IdxWidth-1:0]     grant_q, grant_d;
  logic [IdxWidth-1:0]     last_grant_q, last_grant_d;
  logic                    out_valid_q, out_valid_d;
  logic [DataWidth-1:0]    out_data_q, out_data_d;
  logic                    out_eof_q, out_eof_d;
  logic [BeatCntWidth-1:0] beat_cnt_q, beat_cnt_d;
  logic                    overrun_q, overrun_d;

  logic [IdxWidth-1:0]  pick_grant;
  logic                 pick_any;
  logic                 out_ready;
  logic                 accept;
  logic                 sel_valid;
  logic                 sel_eof;
  logic [DataWidth-1:0] sel_data;

  smi_rr_pick #(
    .NumPorts (NumPorts),
    .IdxWidth (IdxWidth)
  ) u_rr_pick (
    .req_i   (dataInValid),
    .last_i  (last_grant_q),
    .grant_o (pick_grant),
    .any_o   (pick_any)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_eof_d    = out_eof_q;
    beat_cnt_d   = beat_cnt_q;
    overrun_d    = 1'b0;
    dataInStop   = '1;
    accept       = 1'b0;

    // Output register can take a beat if empty or draining this cycle.
    out_ready = !out_valid_q || !dataOutStop;
    sel_valid = dataInValid[grant_q];
    sel_eof   = dataInEofc[grant_q];
    sel_data  = dataIn[grant_q * DataWidth +: DataWidth];

    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          grant_d = pick_grant;
          state_d = StLocked;
        end
      end
      StLocked: begin
        dataInStop[grant_q] = !out_ready;
        accept              = sel_valid && out_ready;
        if (accept) begin
          if (sel_eof) begin
            state_d      = StIdle;
            last_grant_d = grant_q;
            beat_cnt_d   = '0;
          end else if (beat_cnt_q != MaxCnt) begin
            beat_cnt_d = beat_cnt_q + BeatCntWidth'(1);
            overrun_d  = (beat_cnt_q == MaxCnt - BeatCntWidth'(1));
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_eof_d   = sel_eof;
    end else if (out_valid_q && !dataOutStop) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= LastIdx;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_eof_q    <= 1'b0;
      beat_cnt_q   <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_eof_q    <= out_eof_d;
      beat_cnt_q   <= beat_cnt_d;
      overrun_q    <= overrun_d;
    end
  end

  assign dataOutValid = out_valid_q;
  assign dataOut      = out_data_q;
  assign dataOutEofc  = out_eof_q;
  assign grantPort    = grant_q;
  assign frameOverrun = overrun_q;

endmodule

// File: tb/tb_smi_frame_arbiter.sv
// Scoreboard bench for smi_frame_arbiter: per-port sources, expected-output queue.
module tb_smi_frame_arbiter;

  localparam int unsigned NP = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned SrcDepth = 32;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          eof;
  } beat_t;

  logic             clk = 1'b0;
  logic             arstn;
  logic [NP-1:0]    dataInValid;
  logic [NP*DW-1:0] dataIn;
  logic [NP-1:0]    dataInEofc;
  logic [NP-1:0]    dataInStop;
  logic             dataOutValid;
  logic [DW-1:0]    dataOut;
  logic             dataOutEofc;
  logic             dataOutStop;
  logic [1:0]       grantPort;
  logic             frameOverrun;

  smi_frame_arbiter #(
    .DataWidth     (DW),
    .NumPorts      (NP),
    .MaxFrameBeats (4)
  ) dut (
    .clk          (clk),
    .arstn        (arstn),
    .dataInValid  (dataInValid),
    .dataIn       (dataIn),
    .dataInEofc   (dataInEofc),
    .dataInStop   (dataInStop),
    .dataOutValid (dataOutValid),
    .dataOut      (dataOut),
    .dataOutEofc  (dataOutEofc),
    .dataOutStop  (dataOutStop),
    .grantPort    (grantPort),
    .frameOverrun (frameOverrun)
  );

  always #5 clk = ~clk;

  beat_t src_mem [NP][SrcDepth];
  int    src_rd  [NP];
  int    src_wr  [NP];
  beat_t exp_q   [$];
  int    stop_cnt;
  int    ov_cnt;
  int    n_checks;
  int    n_pass;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic add_src(input int p, input logic [DW-1:0] d, input logic e);
    src_mem[p][src_wr[p]] = '{data: d, eof: e};
    src_wr[p]++;
  endtask

  task automatic add_exp(input logic [DW-1:0] d, input logic e);
    exp_q.push_back('{data: d, eof: e});
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check_eq({tag, "_drained"}, exp_q.size(), 0);
  endtask

  // Drive sources and downstream stop on negedge; decide handshakes 1 unit later.
  initial begin
    dataInValid = '0;
    dataIn      = '0;
    dataInEofc  = '0;
    dataOutStop = 1'b0;
    forever begin
      @(negedge clk);
      for (int p = 0; p < NP; p++) begin
        if (src_rd[p] < src_wr[p]) begin
          dataInValid[p]        = 1'b1;
          dataIn[p*DW +: DW]    = src_mem[p][src_rd[p]].data;
          dataInEofc[p]         = src_mem[p][src_rd[p]].eof;
        end else begin
          dataInValid[p]        = 1'b0;
          dataIn[p*DW +: DW]    = '0;
          dataInEofc[p]         = 1'b0;
        end
      end
      dataOutStop = (stop_cnt > 0);
      if (stop_cnt > 0) stop_cnt--;
      #1;
      check_eq("stop_onehot", 32'($countones(~dataInStop) <= 1), 1);
      if (dataOutValid) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_beat", {31'd0, dataOutValid}, 0);
        end else if (!dataOutStop) begin
          beat_t e;
          e = exp_q.pop_front();
          check_eq("out_data", 32'(dataOut), 32'(e.data));
          check_eq("out_eof", {31'd0, dataOutEofc}, {31'd0, e.eof});
        end else begin
          check_eq("hold_data", 32'(dataOut), 32'(exp_q[0].data));
          check_eq("hold_eof", {31'd0, dataOutEofc}, {31'd0, exp_q[0].eof});
        end
      end
      if (frameOverrun) begin
        ov_cnt++;
        check_eq("ovr_beat", 32'(dataOut), 32'h00C4);
      end
      for (int p = 0; p < NP; p++)
        if (dataInValid[p] && !dataInStop[p]) src_rd[p]++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int p = 0; p < NP; p++) begin
      src_rd[p] = 0;
      src_wr[p] = 0;
    end
    stop_cnt = 0;
    ov_cnt   = 0;
    n_checks = 0;
    n_pass   = 0;
    arstn    = 1'b1;
    #1 arstn = 1'b0;
    #1;
    check_eq("rst_valid", {31'd0, dataOutValid}, 0);
    check_eq("rst_data", 32'(dataOut), 0);
    check_eq("rst_eof", {31'd0, dataOutEofc}, 0);
    check_eq("rst_stop", 32'(dataInStop), 32'hF);
    check_eq("rst_grant", 32'(grantPort), 0);
    check_eq("rst_ovr", {31'd0, frameOverrun}, 0);
    repeat (2) @(posedge clk);
    #2 arstn = 1'b1;

    // Ports 1 and 3 both waiting from reset: port 1 first, then 3.
    add_src(1, 16'h0011, 1'b0); add_src(1, 16'h0012, 1'b1);
    add_src(3, 16'h0031, 1'b0); add_src(3, 16'h0032, 1'b1);
    add_exp(16'h0011, 1'b0); add_exp(16'h0012, 1'b1);
    add_exp(16'h0031, 1'b0); add_exp(16'h0032, 1'b1);
    drain("rr_1_3", 40);
    check_eq("grant_after_1_3", 32'(grantPort), 3);

    // All ports valid with single-beat frames: grants rotate 0,1,2,3,0,...
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < NP; p++) begin
        add_src(p, 16'h0400 | 16'(k << 4) | 16'(p), 1'b1);
        add_exp(16'h0400 | 16'(k << 4) | 16'(p), 1'b1);
      end
    drain("rr_all", 60);
    check_eq("grant_after_all", 32'(grantPort), 3);

    // Port 0 three-beat frame with a two-cycle downstream stall mid-frame.
    add_src(0, 16'h00A1, 1'b0); add_src(0, 16'h00A2, 1'b0); add_src(0, 16'h00A3, 1'b1);
    add_exp(16'h00A1, 1'b0); add_exp(16'h00A2, 1'b0); add_exp(16'h00A3, 1'b1);
    for (int i = 0; i < 20 && exp_q.size() != 2; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("stall_sync", exp_q.size(), 2);
    stop_cnt = 2;
    drain("stall", 40);
    check_eq("grant_after_stall", 32'(grantPort), 0);

    // Six-beat frame against MaxFrameBeats=4: one overrun pulse, nothing dropped.
    for (int i = 1; i <= 6; i++) begin
      add_src(2, 16'h00C0 | 16'(i), i == 6);
      add_exp(16'h00C0 | 16'(i), i == 6);
    end
    drain("overrun", 60);
    check_eq("ovr_count", ov_cnt, 1);
    check_eq("grant_after_ovr", 32'(grantPort), 2);

    // Reset after the second beat of a frame is accepted.
    for (int i = 1; i <= 4; i++) add_src(1, 16'h0070 | 16'(i), i == 4);
    add_exp(16'h0071, 1'b0);
    for (int i = 0; i < 20 && src_rd[1] != src_wr[1] - 2; i++) begin
      @(posedge clk);
      #2;
    end
    check_eq("abort_sync", src_rd[1], src_wr[1] - 2);
    arstn = 1'b0;
    #1;
    check_eq("abort_valid", {31'd0, dataOutValid}, 0);
    check_eq("abort_stop", 32'(dataInStop), 32'hF);
    check_eq("abort_grant", 32'(grantPort), 0);
    src_rd[1] = src_wr[1];
    repeat (2) @(posedge clk);
    #2 arstn = 1'b1;
    add_src(1, 16'h0051, 1'b0); add_src(1, 16'h0052, 1'b1);
    add_src(0, 16'h0061, 1'b1);
    add_exp(16'h0061, 1'b1); add_exp(16'h0051, 1'b0); add_exp(16'h0052, 1'b1);
    @(posedge clk);
    #1;
    check_eq("post_rst_idle", {31'd0, dataOutValid}, 0);
    drain("post_rst", 40);
    check_eq("grant_post_rst", 32'(grantPort), 1);
    check_eq("ovr_total", ov_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
